// File: rtl/ssd1306_spi_tx.sv
// SPI mode-0 byte transmitter for the SSD1306 OLED. It keeps CSn low across
// a burst of bytes and releases it after a byte flagged last, followed by a CS gap.
module ssd1306_spi_tx #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       spi_tx_trigger_in,
  input  logic [7:0] spi_data_in,
  input  logic       spi_last_byte_in,
  output logic       spi_ready_out,
  output logic       oled_sclk_out,
  output logic       oled_sdin_out,
  output logic       oled_csn_out
);

  localparam int MAXN = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW   = $clog2(MAXN + 1);
  localparam logic [CW-1:0] DIV_LD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(CS_GAP - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_HIGH   = 3'd2;
  localparam logic [2:0] S_LOW    = 3'd3;
  localparam logic [2:0] S_CS_GAP = 3'd4;

  logic [2:0]    state;
  logic [7:0]    shift_r;
  logic          last_r;
  logic [2:0]    bit_cnt;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state         <= S_IDLE;
      shift_r       <= '0;
      last_r        <= 1'b0;
      bit_cnt       <= '0;
      cnt           <= '0;
      spi_ready_out <= 1'b1;
      oled_sclk_out <= 1'b0;
      oled_sdin_out <= 1'b0;
      oled_csn_out  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (spi_tx_trigger_in) begin
            shift_r       <= spi_data_in;
            last_r        <= spi_last_byte_in;
            bit_cnt       <= 3'd7;
            cnt           <= DIV_LD;
            spi_ready_out <= 1'b0;
            oled_csn_out  <= 1'b0;
            oled_sclk_out <= 1'b0;
            oled_sdin_out <= spi_data_in[7];
            state         <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == '0) begin
            oled_sclk_out <= 1'b1;
            cnt           <= DIV_LD;
            state         <= S_HIGH;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_HIGH: begin
          if (cnt == '0) begin
            oled_sclk_out <= 1'b0;
            cnt           <= DIV_LD;
            state         <= S_LOW;
            // Data changes on the falling edge; after bit 0 it is held.
            if (bit_cnt != 3'd0) begin
              shift_r       <= {shift_r[6:0], 1'b0};
              oled_sdin_out <= shift_r[6];
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_LOW: begin
          if (cnt == '0) begin
            if (bit_cnt == 3'd0) begin
              if (last_r) begin
                oled_csn_out <= 1'b1;
                cnt          <= GAP_LD;
                state        <= S_CS_GAP;
              end else begin
                spi_ready_out <= 1'b1;
                state         <= S_IDLE;
              end
            end else begin
              bit_cnt       <= bit_cnt - 3'd1;
              oled_sclk_out <= 1'b1;
              cnt           <= DIV_LD;
              state         <= S_HIGH;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_CS_GAP: begin
          if (cnt == '0) begin
            spi_ready_out <= 1'b1;
            state         <= S_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state         <= S_IDLE;
          spi_ready_out <= 1'b1;
          oled_sclk_out <= 1'b0;
          oled_csn_out  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// Bench for ssd1306_spi_tx: two instances (CLK_DIV=2/CS_GAP=3 and CLK_DIV=1/CS_GAP=4)
// checked cycle by cycle against a waveform model derived from the byte timing rules.
module tb_ssd1306_spi_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic       last = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] data = 8'h00;
  logic a_ready, a_sclk, a_sdin, a_csn;
  logic b_ready, b_sclk, b_sdin, b_csn;
  logic a_trig, b_trig;
  logic o_ready, o_sclk, o_sdin, o_csn;
  int   checks = 0;
  int   errors = 0;
  int   D = 2;
  int   G = 3;

  always #5 clk = ~clk;

  assign a_trig  = trig & ~sel;
  assign b_trig  = trig & sel;
  assign o_ready = sel ? b_ready : a_ready;
  assign o_sclk  = sel ? b_sclk  : a_sclk;
  assign o_sdin  = sel ? b_sdin  : a_sdin;
  assign o_csn   = sel ? b_csn   : a_csn;

  ssd1306_spi_tx #(.CLK_DIV(2), .CS_GAP(3)) dut_a (
    .clk_in(clk), .reset_in(rst), .spi_tx_trigger_in(a_trig), .spi_data_in(data),
    .spi_last_byte_in(last), .spi_ready_out(a_ready), .oled_sclk_out(a_sclk),
    .oled_sdin_out(a_sdin), .oled_csn_out(a_csn));

  ssd1306_spi_tx #(.CLK_DIV(1), .CS_GAP(4)) dut_b (
    .clk_in(clk), .reset_in(rst), .spi_tx_trigger_in(b_trig), .spi_data_in(data),
    .spi_last_byte_in(last), .spi_ready_out(b_ready), .oled_sclk_out(b_sclk),
    .oled_sdin_out(b_sdin), .oled_csn_out(b_csn));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT ready. mode 0: one-cycle trigger,
  // 1: trigger held while busy, 2: random trigger/data noise while busy.
  task automatic send_byte(input logic [7:0] b, input logic lst, input int mode);
    int n, tot, phase, idx, nr;
    logic prev;
    logic [7:0] rises;
    n = 17 * D;
    tot = n + 1 + (lst ? G : 0);
    nr = 0;
    prev = 1'b0;
    rises = 8'h00;
    trig = 1'b1; data = b; last = lst;
    @(posedge clk);
    for (int k = 1; k <= tot; k++) begin
      @(negedge clk);
      phase = (k - 1) / D;
      idx = (phase / 2 > 7) ? 7 : phase / 2;
      chk("sclk", o_sclk, (k <= n && phase % 2 == 1) ? 1 : 0);
      chk("csn", o_csn, (k <= n) ? 0 : (lst ? 1 : 0));
      chk("ready", o_ready, (k <= n) ? 0 : ((!lst || k >= n + 1 + G) ? 1 : 0));
      if (k <= n) chk("sdin", o_sdin, b[7 - idx]);
      if (o_sclk && !prev) begin
        if (nr < 8) rises[7 - nr] = o_sdin;
        nr++;
      end
      prev = o_sclk;
      if (k >= n || mode == 0) trig = 1'b0;
      else if (mode == 1) trig = 1'b1;
      else begin
        trig = 1'($urandom);
        data = 8'($urandom);
        last = 1'($urandom);
      end
    end
    chk("rise_count", nr, 8);
    chk("byte_bits", rises, b);
  endtask

  task automatic idle_chk(input int n, input logic exp_csn);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_sclk", o_sclk, 0);
      chk("idle_csn", o_csn, exp_csn);
      chk("idle_ready", o_ready, 1);
    end
  endtask

  initial begin
    int nr, guard;
    logic prev;
    repeat (2) @(negedge clk);
    chk("rst_a_ready", a_ready, 1); chk("rst_a_sclk", a_sclk, 0);
    chk("rst_a_sdin", a_sdin, 0);   chk("rst_a_csn", a_csn, 1);
    chk("rst_b_ready", b_ready, 1); chk("rst_b_sclk", b_sclk, 0);
    chk("rst_b_sdin", b_sdin, 0);   chk("rst_b_csn", b_csn, 1);
    rst = 1'b0;
    @(negedge clk);

    sel = 1'b0; D = 2; G = 3;
    send_byte(8'hA5, 1'b1, 0);
    idle_chk(3, 1'b1);
    send_byte(8'h3C, 1'b0, 0);
    send_byte(8'hC3, 1'b1, 0);
    send_byte(8'($urandom), 1'b1, 2);
    idle_chk(4, 1'b1);
    send_byte(8'($urandom), 1'b1, 1);
    idle_chk(4, 1'b1);

    // Reset after the third SCLK rise aborts the byte.
    trig = 1'b1; data = 8'h5A; last = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    nr = 0; guard = 0; prev = 1'b0;
    while (nr < 3 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (o_sclk && !prev) nr++;
      prev = o_sclk;
    end
    chk("rst_wait_rises", nr, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", o_ready, 1); chk("abort_csn", o_csn, 1);
    chk("abort_sclk", o_sclk, 0);   chk("abort_sdin", o_sdin, 0);
    send_byte(8'hFF, 1'b1, 0);

    // Reset wins over a simultaneous trigger.
    trig = 1'b1; rst = 1'b1; data = 8'h81; last = 1'b0;
    @(negedge clk);
    trig = 1'b0; rst = 1'b0;
    chk("rst_trig_ready", o_ready, 1);
    chk("rst_trig_csn", o_csn, 1);
    idle_chk(5, 1'b1);

    send_byte(8'h00, 1'b0, 0);
    idle_chk(10, 1'b0);
    send_byte(8'($urandom), 1'b1, 0);

    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'($urandom), 0);
    send_byte(8'($urandom), 1'b1, 0);

    sel = 1'b1; D = 1; G = 4;
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'($urandom), 0);
    send_byte(8'($urandom), 1'b1, 2);
    idle_chk(3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
